// File: rtl/i2c_defs_pkg.sv
// Shared constants for the I2C master datapaths (write now, read later).
// Pad-drive and acknowledge encodings live here so both datapaths agree.
package i2c_defs;

    localparam int I2C_DATA_WIDTH          = 8;
    localparam int I2C_HALF_PERIOD_DEFAULT = 250;

    // Encodings of SDAPullLow as seen by the open-drain pad cell.
    localparam logic SDA_RELEASE = 1'b0;
    localparam logic SDA_PULL    = 1'b1;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_baud_generator.sv
// Free-running I2C baud clock with single-cycle rise/fall flags.
// Shared between the write datapath and the upcoming read datapath.
module i2c_baud_generator
    import i2c_defs::*;
#(
    parameter int HALF_PERIOD = I2C_HALF_PERIOD_DEFAULT
) (
    input  logic clock,
    input  logic Reset,
    output logic ClockI2C,
    output logic BaudRise,
    output logic BaudFall
);

    localparam int CountWidth = (HALF_PERIOD > 2) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CountWidth-1:0] LastCount = CountWidth'(HALF_PERIOD - 1);

    logic [CountWidth-1:0] baudCount;
    logic                  baudWrap;

    assign baudWrap = (baudCount == LastCount);

    // The edge flags are registered alongside the toggle so they line up
    // with the cycle in which ClockI2C already shows its new level.
    always_ff @(posedge clock) begin
        if (Reset) begin
            baudCount <= '0;
            ClockI2C  <= 1'b1;
            BaudRise  <= 1'b0;
            BaudFall  <= 1'b0;
        end else begin
            BaudRise <= 1'b0;
            BaudFall <= 1'b0;
            if (baudWrap) begin
                baudCount <= '0;
                ClockI2C  <= ~ClockI2C;
                BaudRise  <= ~ClockI2C;
                BaudFall  <= ClockI2C;
            end else begin
                baudCount <= baudCount + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_write_datapath.sv
// Bit-level write datapath: SCL/SDA drive, byte shifter and ACK capture,
// steered cycle by cycle by the I2C controller strobes.
module i2c_write_datapath
    import i2c_defs::*;
#(
    parameter int HALF_PERIOD = I2C_HALF_PERIOD_DEFAULT,
    parameter int DATA_WIDTH  = I2C_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] DataIn,
    input  logic                  BaudEnable,
    input  logic                  ReadorWrite,
    input  logic                  Select,
    input  logic                  ShiftorHold,
    input  logic                  StartStopAck,
    input  logic                  WriteLoad,
    input  logic                  SDAIn,
    output logic                  ClockI2C,
    output logic                  SCL,
    output logic                  SDAPullLow,
    output logic                  ACKbit,
    output logic                  ACKValid,
    output logic [3:0]            ShiftCount
);

    localparam logic [3:0] MaxCount = 4'(DATA_WIDTH);

    logic                  baudRise;
    logic                  baudFallUnused;
    logic [DATA_WIDTH-1:0] shiftReg;
    logic                  sdaLevel;
    logic                  sdaSync1;
    logic                  sdaSync2;

    // Falling-edge flag is only consumed by the read datapath.
    i2c_baud_generator #(
        .HALF_PERIOD(HALF_PERIOD)
    ) baudGen (
        .clock   (clock),
        .Reset   (Reset),
        .ClockI2C(ClockI2C),
        .BaudRise(baudRise),
        .BaudFall(baudFallUnused)
    );

    // A load always beats a shift so the controller can reuse its bit strobe.
    always_ff @(posedge clock) begin
        if (Reset) begin
            shiftReg   <= '0;
            ShiftCount <= '0;
        end else if (WriteLoad) begin
            shiftReg   <= DataIn;
            ShiftCount <= '0;
        end else if (ShiftorHold) begin
            shiftReg <= {shiftReg[DATA_WIDTH-2:0], 1'b0};
            if (ShiftCount != MaxCount) begin
                ShiftCount <= ShiftCount + 1'b1;
            end
        end
    end

    assign sdaLevel = Select ? shiftReg[DATA_WIDTH-1] : StartStopAck;

    always_ff @(posedge clock) begin
        if (Reset) begin
            SCL        <= 1'b1;
            SDAPullLow <= SDA_RELEASE;
        end else begin
            SCL        <= BaudEnable ? ClockI2C : 1'b1;
            SDAPullLow <= (!ReadorWrite && !sdaLevel) ? SDA_PULL : SDA_RELEASE;
        end
    end

    // SDAIn is asynchronous to clock, so it is only looked at after two flops.
    always_ff @(posedge clock) begin
        if (Reset) begin
            sdaSync1 <= 1'b1;
            sdaSync2 <= 1'b1;
            ACKbit   <= NACK;
            ACKValid <= 1'b0;
        end else begin
            sdaSync1 <= SDAIn;
            sdaSync2 <= sdaSync1;
            ACKValid <= 1'b0;
            if (baudRise && ReadorWrite) begin
                ACKbit   <= sdaSync2;
                ACKValid <= 1'b1;
            end
        end
    end

endmodule
